alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Sweeps all eight ALU opcodes over latched operands and captures each {CI_OUT,F} result.
// Define ALU_SEQ_LOOP_EN to let a held START chain sweeps back-to-back at the DONE edge.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [3:0] A_IN,
  input  logic [3:0] B_IN,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       M,
  output logic       S1,
  output logic       S0,
  input  logic [3:0] F,
  input  logic       CI_OUT,
  output logic       RES_VALID,
  output logic [2:0] RES_OP,
  output logic [4:0] RES_DATA,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {StIdle, StSettle, StCapture} stateT;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  stateT      stateQ, stateD;
  logic [3:0] cntQ, cntD;
  logic [2:0] opQ, opD;
  logic [3:0] aQ, aD, bQ, bD;
  logic       resValidQ, resValidD;
  logic [2:0] resOpQ, resOpD;
  logic [4:0] resDataQ, resDataD;
  logic       busyQ, busyD;
  logic       doneQ, doneD;
  // Set once START has been seen low in IDLE; a sweep may only launch while armed.
  logic       armedQ, armedD;
  logic       startOk;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateQ    <= StIdle;
      cntQ      <= 4'd0;
      opQ       <= 3'd0;
      aQ        <= 4'd0;
      bQ        <= 4'd0;
      resValidQ <= 1'b0;
      resOpQ    <= 3'd0;
      resDataQ  <= 5'd0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
      armedQ    <= 1'b1;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      opQ       <= opD;
      aQ        <= aD;
      bQ        <= bD;
      resValidQ <= resValidD;
      resOpQ    <= resOpD;
      resDataQ  <= resDataD;
      busyQ     <= busyD;
      doneQ     <= doneD;
      armedQ    <= armedD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    opD       = opQ;
    aD        = aQ;
    bD        = bQ;
    resValidD = 1'b0;
    resOpD    = resOpQ;
    resDataD  = resDataQ;
    busyD     = busyQ;
    doneD     = 1'b0;
    armedD    = armedQ;
`ifdef ALU_SEQ_LOOP_EN
    startOk   = START;
`else
    startOk   = START && armedQ;
`endif

    unique case (stateQ)
      StIdle: begin
        if (!START) begin
          armedD = 1'b1;
        end
        if (startOk) begin
          aD     = A_IN;
          bD     = B_IN;
          opD    = 3'd0;
          cntD   = 4'd0;
          busyD  = 1'b1;
          armedD = 1'b0;
          stateD = StSettle;
        end
      end
      StSettle: begin
        if (cntQ == SettleLast) begin
          cntD   = 4'd0;
          stateD = StCapture;
        end else begin
          cntD = cntQ + 4'd1;
        end
      end
      StCapture: begin
        resValidD = 1'b1;
        resOpD    = opQ;
        resDataD  = {CI_OUT, F};
        if (opQ != 3'd7) begin
          opD    = opQ + 3'd1;
          stateD = StSettle;
        end else begin
          doneD  = 1'b1;
          busyD  = 1'b0;
          stateD = StIdle;
`ifdef ALU_SEQ_LOOP_EN
          // Chain straight into the next sweep; BUSY never drops.
          if (START) begin
            aD     = A_IN;
            bD     = B_IN;
            opD    = 3'd0;
            busyD  = 1'b1;
            armedD = 1'b0;
            stateD = StSettle;
          end
`endif
        end
      end
      default: stateD = StIdle;
    endcase
  end

  assign A         = aQ;
  assign B         = bQ;
  assign M         = opQ[2];
  assign S1        = opQ[1];
  assign S0        = opQ[0];
  assign RES_VALID = resValidQ;
  assign RES_OP    = resOpQ;
  assign RES_DATA  = resDataQ;
  assign BUSY      = busyQ;
  assign DONE      = doneQ;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a behavioural ALU answers the opcodes, stimulus
// queues expected results, and a negedge monitor pops and compares each RES_VALID pulse.
module tb_alu_op_sequencer;

  localparam int Period = 3;  // SETTLE_CYCLES + 1 for the main instance

  // Expected results, op7 in the top slice down to op0 in the bottom slice.
  localparam logic [39:0] Hand1 = {5'h04, 5'h06, 5'h0A, 5'h01, 5'h05, 5'h04, 5'h01, 5'h09};
  localparam logic [39:0] Hand2 = {5'h05, 5'h0B, 5'h05, 5'h0F, 5'h0F, 5'h00, 5'h05, 5'h0F};

  typedef struct {
    logic [2:0] op;
    logic [4:0] data;
    int         edgeAt;
  } expT;

  logic       CLK, RST_N, START;
  logic [3:0] A_IN, B_IN, A, B, F;
  logic       M, S1, S0, CI_OUT, RES_VALID, BUSY, DONE;
  logic [2:0] RES_OP;
  logic [4:0] RES_DATA;

  logic       u1Start;
  logic [3:0] u1AIn, u1BIn, u1A, u1B, u1F;
  logic       u1M, u1S1, u1S0, u1Co, u1Valid, u1Busy, u1Done;
  logic [2:0] u1ResOp;
  logic [4:0] u1ResData;

  expT        expQ[$];
  int         edgeCnt = 0;
  int         nChecks = 0;
  int         nPass = 0;
  logic [2:0] lastOp;
  logic [4:0] lastData;

  function automatic logic [4:0] aluModel(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {1'b0, a} + 5'd1;
      default: return {1'b0, b};
    endcase
  endfunction

  function automatic logic [39:0] modelAll(input logic [3:0] a, input logic [3:0] b);
    logic [39:0] r;
    for (int k = 0; k < 8; k++) r[k*5 +: 5] = aluModel(3'(k), a, b);
    return r;
  endfunction

  // F is corrupted during each RES_VALID cycle so a late re-capture would be visible.
  assign {CI_OUT, F} = aluModel({M, S1, S0}, A, B) ^ {1'b0, {4{RES_VALID}}};
  assign {u1Co, u1F} = aluModel({u1M, u1S1, u1S0}, u1A, u1B);

  alu_op_sequencer #(.SETTLE_CYCLES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A_IN(A_IN), .B_IN(B_IN),
    .A(A), .B(B), .M(M), .S1(S1), .S0(S0), .F(F), .CI_OUT(CI_OUT),
    .RES_VALID(RES_VALID), .RES_OP(RES_OP), .RES_DATA(RES_DATA), .BUSY(BUSY), .DONE(DONE)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(1)) u1 (
    .CLK(CLK), .RST_N(RST_N), .START(u1Start), .A_IN(u1AIn), .B_IN(u1BIn),
    .A(u1A), .B(u1B), .M(u1M), .S1(u1S1), .S0(u1S0), .F(u1F), .CI_OUT(u1Co),
    .RES_VALID(u1Valid), .RES_OP(u1ResOp), .RES_DATA(u1ResData), .BUSY(u1Busy),
    .DONE(u1Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) edgeCnt++;

  task automatic chk(input string name, input logic ok, input int act, input int exp);
    nChecks++;
    if (ok) nPass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
                  name, act, act, exp, exp, edgeCnt);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_A"}, A == 4'd0, int'(A), 0);
    chk({tag, "_B"}, B == 4'd0, int'(B), 0);
    chk({tag, "_op"}, {M, S1, S0} == 3'd0, int'({M, S1, S0}), 0);
    chk({tag, "_valid"}, RES_VALID == 1'b0, int'(RES_VALID), 0);
    chk({tag, "_resop"}, RES_OP == 3'd0, int'(RES_OP), 0);
    chk({tag, "_resdata"}, RES_DATA == 5'd0, int'(RES_DATA), 0);
    chk({tag, "_busy_done"}, {BUSY, DONE} == 2'b00, int'({BUSY, DONE}), 0);
  endtask

  // Returns #1 after the edge that samples START.
  task automatic startSweep(input logic [3:0] a, input logic [3:0] b, input logic [39:0] ex);
    int s;
    @(posedge CLK);
    #1;
    A_IN  = a;
    B_IN  = b;
    START = 1'b1;
    s = edgeCnt + 1;
    for (int k = 0; k < 8; k++) expQ.push_back('{3'(k), ex[k*5 +: 5], s + (k + 1) * Period});
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 60 && expQ.size() != 0; i++) @(posedge CLK);
    #1;
    chk(name, expQ.size() == 0, expQ.size(), 0);
    expQ.delete();
    repeat (4) @(posedge CLK);
  endtask

  // Monitor: every RES_VALID must match the head of the queue; outputs hold otherwise.
  always @(negedge CLK) begin
    expT e;
    if (!RST_N) begin
      lastOp   = 3'd0;
      lastData = 5'd0;
    end else if (RES_VALID) begin
      if (expQ.size() == 0) begin
        chk("unexpected_valid", 1'b0, int'(RES_OP), -1);
      end else begin
        e = expQ.pop_front();
        chk("res_op", RES_OP == e.op, int'(RES_OP), int'(e.op));
        chk("res_data", RES_DATA == e.data, int'(RES_DATA), int'(e.data));
        chk("valid_cycle", edgeCnt == e.edgeAt, edgeCnt, e.edgeAt);
        chk("done_flag", DONE == (e.op == 3'd7), int'(DONE), int'(e.op == 3'd7));
        chk("busy_flag", BUSY == (e.op != 3'd7), int'(BUSY), int'(e.op != 3'd7));
        lastOp   = e.op;
        lastData = e.data;
      end
    end else begin
      chk("hold", RES_OP == lastOp && RES_DATA == lastData && !DONE,
          int'({DONE, RES_OP, RES_DATA}), int'({1'b0, lastOp, lastData}));
    end
  end

  initial begin
    int s, rel, nValid, busyLow, firstDone, nDone;
    RST_N = 1'b0; START = 1'b0; A_IN = 4'd0; B_IN = 4'd0;
    u1Start = 1'b0; u1AIn = 4'h3; u1BIn = 4'h1;
    #2;
    chkAllZero("reset");
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    // Basic sweep with hand-computed results.
    startSweep(4'b0101, 4'b0100, Hand1);
    chk("busy_start", BUSY == 1'b1, int'(BUSY), 1);
    waitDrain("drain_sweep1");

    // Operands frozen and START ignored while busy.
    startSweep(4'b1010, 4'b0101, Hand2);
    repeat (5) @(posedge CLK);
    #1;
    A_IN  = 4'b1111;
    START = 1'b1;
    chk("a_frozen", A == 4'b1010, int'(A), 10);
    @(posedge CLK);
    #1;
    START = 1'b0;
    chk("a_frozen2", A == 4'b1010, int'(A), 10);
    chk("busy_mid", BUSY == 1'b1, int'(BUSY), 1);
    repeat (8) @(posedge CLK);
    #1;
    chk("a_frozen3", A == 4'b1010 && B == 4'b0101, int'({A, B}), 8'h A5);
    waitDrain("drain_sweep2");

    // Asynchronous reset during op 3 settle aborts the sweep.
    startSweep(4'b0011, 4'b0110, modelAll(4'b0011, 4'b0110));
    repeat (9) @(posedge CLK);
    #1;
    chk("op3_settle", {M, S1, S0} == 3'd3, int'({M, S1, S0}), 3);
    #2;
    RST_N = 1'b0;
    expQ.delete();
    #1;
    chkAllZero("async_reset");
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (30) @(posedge CLK);
    startSweep(4'b0011, 4'b0110, modelAll(4'b0011, 4'b0110));
    waitDrain("drain_after_reset");

    // START held high on the SETTLE_CYCLES=1 instance.
    @(posedge CLK);
    #1;
    u1Start = 1'b1;
    s = edgeCnt + 1;
    nValid = 0; busyLow = 0; firstDone = -1; nDone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK);
      #1;
      rel = edgeCnt - s;
      if (u1Valid) begin
        nValid++;
        chk("u1_valid_spacing", rel % 2 == 0 && rel >= 2, rel, 2);
      end
      if (u1Done) begin
        nDone++;
        if (firstDone < 0) firstDone = rel;
      end
      if (!u1Busy) busyLow++;
    end
    chk("u1_first_done", firstDone == 16, firstDone, 16);
`ifdef ALU_SEQ_LOOP_EN
    chk("u1_loop_valids", nValid == 19, nValid, 19);
    chk("u1_loop_dones", nDone == 2, nDone, 2);
    chk("u1_loop_busy", busyLow == 0, busyLow, 0);
    u1Start = 1'b0;
    repeat (20) @(posedge CLK);
`else
    chk("u1_single_valids", nValid == 8, nValid, 8);
    chk("u1_single_dones", nDone == 1, nDone, 1);
    chk("u1_idle_busy_low", busyLow == 24, busyLow, 24);
    u1Start = 1'b0;
    @(posedge CLK);
    #1;
    chk("u1_no_restart", u1Busy == 1'b0, int'(u1Busy), 0);
    u1Start = 1'b1;
    @(posedge CLK);
    #1;
    u1Start = 1'b0;
    chk("u1_rearmed", u1Busy == 1'b1, int'(u1Busy), 1);
    repeat (20) @(posedge CLK);
`endif

    #1;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got edge %0d, expected completion", edgeCnt);
    $fatal(1, "timeout");
  end

endmodule
